// File: rtl/mem_data_pkg.sv
// Load-size encodings and field-width helper shared by the memory-data buffer and its extractor.
package mem_data_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_FULL = 2'd3;

  // Width of the loaded field; SIZE_FULL follows the memory word width.
  function automatic int unsigned size_bits(input logic [1:0] size, input int unsigned data_width);
    case (size)
      SIZE_BYTE: return 8;
      SIZE_HALF: return 16;
      SIZE_WORD: return 32;
      default:   return data_width;
    endcase
  endfunction

endpackage

// File: rtl/mem_data_extract.sv
// Combinational field select and sign/zero extension of a raw memory word, plus the alignment check.
// No state, zero latency, no flow control of its own.
module mem_data_extract
  import mem_data_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFS_W      = $clog2(DATA_WIDTH/8)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [OFS_W-1:0]      offset,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  aligned
);

  logic [OFS_W+2:0]      shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] msb_mask;
  logic [OFS_W-1:0]      align_mask;
  logic                  sign_bit;

  always_comb begin
    shamt    = {offset, 3'b000};
    shifted  = data >> shamt;
    // Shifting all-ones by the full width yields zero, so SIZE_FULL gets an all-ones mask.
    mask     = ~({DATA_WIDTH{1'b1}} << size_bits(size, DATA_WIDTH));
    msb_mask = mask ^ (mask >> 1);
    sign_bit = |(shifted & msb_mask);
    result   = (shifted & mask) | ((sign_ext && sign_bit) ? ~mask : '0);

    case (size)
      SIZE_BYTE: align_mask = '0;
      SIZE_HALF: align_mask = OFS_W'(1);
      SIZE_WORD: align_mask = OFS_W'(3);
      default:   align_mask = '1;
    endcase
    aligned = (offset & align_mask) == '0;
  end

endmodule

// File: rtl/mem_data_buffer.sv
// Load-data FIFO: extracts/extends on enqueue, first-word fall-through with 1-cycle enqueue-to-valid latency.
// in_ready drops when full (no bypass, no push-on-pop when full); out_valid/in_ready depend only on registered count.
module mem_data_buffer
  import mem_data_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int OFS_W      = $clog2(DATA_WIDTH/8)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [1:0]                in_size,
  input  logic                      in_signed,
  input  logic [OFS_W-1:0]          in_offset,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      misalign
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  ext_aligned;
  logic                  handshake;
  logic                  push;
  logic                  pop;

  mem_data_extract #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFS_W      (OFS_W)
  ) u_extract (
    .data     (in_data),
    .size     (in_size),
    .sign_ext (in_signed),
    .offset   (in_offset),
    .result   (ext_data),
    .aligned  (ext_aligned)
  );

  assign in_ready  = count_q < CNT_W'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign count     = count_q;

  assign handshake = in_valid & in_ready;
  assign push      = handshake & ext_aligned & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      misalign <= 1'b0;
    end else if (flush) begin
      count_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= handshake & ~ext_aligned;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: out_data is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ext_data;
  end

endmodule

// File: tb/tb_mem_data_buffer.sv
// Directed and randomized checks of mem_data_buffer (DATA_WIDTH=32, DEPTH=4) against a queue-based reference.
module tb_mem_data_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_size;
  logic          in_signed;
  logic [1:0]    in_offset;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
  logic          misalign;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q [$];
  logic          exp_misalign;

  mem_data_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_size   (in_size),
    .in_signed (in_signed),
    .in_offset (in_offset),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_extract(input logic [DW-1:0] d, input int sz, input int ofs, input bit sg);
    longint bits;
    longint lim;
    longint f;
    bits = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
    lim  = longint'(1) << bits;
    f    = (longint'({32'b0, d}) >> (8 * ofs)) % lim;
    if (sg && f >= lim / 2) f = f - lim;
    return f[DW-1:0];
  endfunction

  function automatic bit ref_aligned(input int sz, input int ofs);
    int bytes;
    bytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    return (ofs % bytes) == 0;
  endfunction

  task automatic check(input string tag);
    logic [DW-1:0] exp_data;
    logic [2:0]    exp_count;
    exp_data  = (exp_q.size() != 0) ? exp_q[0] : '0;
    exp_count = 3'(exp_q.size());
    n_cmp++;
    assert (out_valid === (exp_q.size() != 0)) else begin
      n_err++; $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, exp_q.size() != 0);
    end
    n_cmp++;
    assert (out_data === exp_data) else begin
      n_err++; $error("FAIL %s out_data: observed %h expected %h", tag, out_data, exp_data);
    end
    n_cmp++;
    assert (count === exp_count) else begin
      n_err++; $error("FAIL %s count: observed %0d expected %0d", tag, count, exp_count);
    end
    n_cmp++;
    assert (in_ready === (exp_q.size() < DEPTH)) else begin
      n_err++; $error("FAIL %s in_ready: observed %b expected %b", tag, in_ready, exp_q.size() < DEPTH);
    end
    n_cmp++;
    assert (misalign === exp_misalign) else begin
      n_err++; $error("FAIL %s misalign: observed %b expected %b", tag, misalign, exp_misalign);
    end
  endtask

  // Drive one cycle's inputs, check current outputs, advance the model, then move past the edge.
  task automatic step(input string tag, input bit v, input logic [DW-1:0] d, input int sz,
                      input bit sg, input int ofs, input bit ordy, input bit fl);
    bit full;
    bit hs;
    bit do_pop;
    in_valid  = v;
    in_data   = d;
    in_size   = 2'(sz);
    in_signed = sg;
    in_offset = 2'(ofs);
    out_ready = ordy;
    flush     = fl;
    check(tag);
    full   = exp_q.size() == DEPTH;
    hs     = v && !full;
    do_pop = exp_q.size() != 0 && ordy;
    if (fl) begin
      exp_q.delete();
      exp_misalign = 1'b0;
    end else begin
      exp_misalign = hs && !ref_aligned(sz, ofs);
      if (do_pop) void'(exp_q.pop_front());
      if (hs && ref_aligned(sz, ofs)) exp_q.push_back(ref_extract(d, sz, ofs, sg));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_size = '0; in_signed = 1'b0; in_offset = '0; out_ready = 1'b0;
    exp_misalign = 1'b0;
    #12;
    check("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Byte extraction, signed then unsigned.
    step("byte_s_push", 1, 32'h80F1_7F02, 0, 1, 3, 0, 0);
    n_cmp++;
    assert (out_data === 32'hFFFF_FF80) else begin
      n_err++; $error("FAIL byte_signed: observed %h expected %h", out_data, 32'hFFFF_FF80);
    end
    step("byte_s_pop", 0, 0, 0, 0, 0, 1, 0);
    step("byte_u_push", 1, 32'h80F1_7F02, 0, 0, 3, 0, 0);
    n_cmp++;
    assert (out_data === 32'h0000_0080) else begin
      n_err++; $error("FAIL byte_unsigned: observed %h expected %h", out_data, 32'h0000_0080);
    end
    step("byte_u_pop", 0, 0, 0, 0, 0, 1, 0);

    // Halfword extraction.
    step("half_push", 1, 32'h1234_8001, 1, 1, 2, 0, 0);
    n_cmp++;
    assert (out_data === 32'h0000_1234) else begin
      n_err++; $error("FAIL half_signed: observed %h expected %h", out_data, 32'h0000_1234);
    end
    step("half_pop", 0, 0, 0, 0, 0, 1, 0);

    // Misaligned halfword: pulse for one cycle, nothing stored.
    step("mis_push", 1, 32'hDEAD_BEEF, 1, 0, 1, 0, 0);
    step("mis_pulse", 0, 0, 0, 0, 0, 0, 0);
    step("mis_after", 0, 0, 0, 0, 0, 0, 0);

    // Fill past capacity, then drain in order.
    for (int i = 1; i <= 5; i++) step("fill", 1, DW'(i), 2, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("drain", 0, 0, 0, 0, 0, 1, 0);

    // Push and pop together at count 2, then sustained pop-rate pushes across the wrap.
    step("pp_fill", 1, 32'hA1, 2, 0, 0, 0, 0);
    step("pp_fill", 1, 32'hA2, 2, 0, 0, 0, 0);
    step("pp_both", 1, 32'hA3, 2, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step("pp_wrap", 1, 32'hB0 + DW'(i), 2, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("pp_drain", 0, 0, 0, 0, 0, 1, 0);

    // Flush with a push in the same cycle.
    for (int i = 0; i < 3; i++) step("fl_fill", 1, 32'hC0 + DW'(i), 2, 0, 0, 0, 0);
    step("fl_flush", 1, 32'hCC, 2, 0, 0, 1, 1);
    step("fl_after", 0, 0, 0, 0, 0, 0, 0);

    // Refill, then async reset between edges.
    step("rst_fill", 1, 32'hD1, 2, 0, 0, 0, 0);
    step("rst_fill", 1, 32'hD2, 2, 0, 0, 0, 0);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    exp_q.delete();
    exp_misalign = 1'b0;
    #1;
    check("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_reset");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int sz;
      int ofs;
      sz  = int'($urandom_range(0, 3));
      ofs = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      step("rand", $urandom_range(0, 3) != 0, $urandom, sz, $urandom_range(0, 1) == 1, ofs,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_data_buffer.md
# mem_data_buffer

Parametrised memory-data register for the multicycle datapath: captures load data returned by the memory unit, extracts and extends the addressed byte, halfword, word or full-width value, and holds results in a small FIFO. The datapath drains the FIFO with a valid/ready handshake. This decouples memory return timing from register-file write-back and supports more than one outstanding load.

## Interface
- DATA_WIDTH, 32: memory word width in bits; legal values are 32 and 64.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- OFS_W, $clog2(DATA_WIDTH/8): derived byte-offset width; not overridden.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  memory data present.
- in_ready  output  1  entry accepted this cycle when high together with in_valid.
- in_data  input  DATA_WIDTH  raw memory word.
- in_size  input  2  load size: 0 byte, 1 halfword, 2 word (32b), 3 full DATA_WIDTH.
- in_signed  input  1  1 sign-extends, 0 zero-extends.
- in_offset  input  OFS_W  byte offset within the word.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  DATA_WIDTH  extracted and extended head entry.
- count  output  $clog2(DEPTH)+1  occupied entries.
- misalign  output  1  one-cycle pulse when a misaligned load is rejected.

## Operation
- Extraction happens on enqueue. The selected field is in_data[8*in_offset +: size_bits], extended to DATA_WIDTH and stored.
- size_bits is 8, 16, 32 or DATA_WIDTH. With DATA_WIDTH=32, size 2 and size 3 are identical.
- Alignment rule: in_offset must be a multiple of size_bits/8. Size 3 requires in_offset=0.
- Misaligned handshake (in_valid & in_ready): the load is not stored. misalign is high the next cycle for one cycle. count is unchanged.
- in_ready = (count < DEPTH). A push while full is not accepted, even if a pop occurs in the same cycle. There is no bypass path.
- Pop occurs when out_valid & out_ready. out_valid = (count != 0). out_data is the head entry (first-word fall-through).
- Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
- Push and pop wrap modulo DEPTH.
- flush has priority over push and pop in the same cycle. Next state: count=0 and pointers=0. Storage contents do not matter. No misalign pulse is generated.
- out_data is 0 whenever out_valid is 0.

## Timing
- Reset values: count=0, out_valid=0, out_data=0, misalign=0, in_ready=1, pointers=0.
- Reset asserted mid-operation clears all state with no clock edge. Entries in flight are lost.
- Enqueue-to-out_valid latency: 1 cycle. A push at edge N gives out_valid=1 after edge N.
- in_ready and out_valid are functions of registered count only. There is no combinational path from in_valid or out_ready.
- misalign is registered: it asserts in the cycle after the rejected handshake.

## Structure
- Package mem_data_pkg holds:
  - the size encodings SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2, SIZE_FULL=2'd3;
  - the function returning size_bits for a given encoding.
- Sub-module mem_data_extract is purely combinational. It computes the field select, the extension and the aligned flag, and is used by the enqueue path.
- FIFO storage is a register array of DEPTH x DATA_WIDTH. Pointers are $clog2(DEPTH) bits wide.

## Test plan
- Byte extraction, DATA_WIDTH=32: reset, then push in_data=32'h80F1_7F02, size=0, offset=3, signed=1. Expected: out_valid next cycle, out_data=32'hFFFF_FF80. Repeat with signed=0; expected out_data=32'h0000_0080.
- Halfword extraction: push 32'h1234_8001, size=1, offset=2, signed=1. Expected out_data=32'h0000_1234.
- Misalign: push size=1, offset=1. Expected: misalign high for exactly 1 cycle, count stays 0, out_valid stays 0.
- Full FIFO, DEPTH=4, out_ready=0: push 5 words 1..5. Expected: in_ready low after the 4th push and word 5 not accepted. Then drain with out_ready=1; expected sequence 1,2,3,4 and count returns to 0.
- Simultaneous push/pop with count=2: after one cycle count stays 2 and order is preserved. Also push 6 words at pop rate to exercise pointer wrap.
- Flush and async reset: with count=3, assert flush together with in_valid. Expected count=0 next cycle and nothing enqueued. Refill, then assert reset between edges. Expected: out_valid=0 and out_data=0 immediately, before the next posedge.
